// File: rtl/button_debouncer_pkg.sv
// Shared definitions for the push-button debouncer.
//   state_t              : debounce FSM state encoding
//   DEF_STABLE_CYCLES    : default acceptance window (1 ms at 50 MHz)
//   DEF_LONG_WINDOWS     : default number of windows before a long press
//   DEF_CNT_W/DEF_LONG_W : default counter widths
package button_debouncer_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   localparam int DEF_STABLE_CYCLES = 50000;
   localparam int DEF_LONG_WINDOWS  = 1000;
   localparam int DEF_CNT_W         = 16;
   localparam int DEF_LONG_W        = 10;

endpackage

// File: rtl/button_debouncer_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
//   clk_i : sampling clock
//   rst_i : synchronous active-high reset, loads RST_VAL into both flops
//   d_i   : asynchronous input
//   q_o   : synchronized output (two clock edges of latency)
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/button_debouncer.sv
// Debouncer for an active-low bouncing board button.
// A raw level must hold for STABLE_CYCLES consecutive cycles before it is
// accepted. Optional long-press detection is compiled in when the macro
// BUTTON_DEBOUNCER_LONGPRESS_EN is defined.
//   Clock       : system clock, all state on rising edge
//   Reset       : synchronous active-high reset
//   ButtonRaw_n : raw asynchronous button, active-low
//   Level       : debounced pressed level (1 = pressed)
//   Press       : one-cycle pulse when a press is accepted
//   Release     : one-cycle pulse when a release is accepted
//   LongPress   : one-cycle pulse after LONG_WINDOWS full windows held
//                 (tied 0 without BUTTON_DEBOUNCER_LONGPRESS_EN)
module button_debouncer
   import button_debouncer_pkg::*;
#(
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int CNT_W         = DEF_CNT_W,
   parameter int LONG_WINDOWS  = DEF_LONG_WINDOWS,
   parameter int LONG_W        = DEF_LONG_W
) (
   input  logic Clock,
   input  logic Reset,
   input  logic ButtonRaw_n,
   output logic Level,
   output logic Press,
   output logic Release,
   output logic LongPress
);

   generate
      if (STABLE_CYCLES < 2 || STABLE_CYCLES > (1 << CNT_W) - 1) begin : g_bad_stable
         $error("button_debouncer: STABLE_CYCLES out of range for CNT_W");
      end
      if (LONG_WINDOWS < 1 || LONG_WINDOWS > (1 << LONG_W) - 1) begin : g_bad_long
         $error("button_debouncer: LONG_WINDOWS out of range for LONG_W");
      end
   endgenerate

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic              raw_sync;
   logic              s;
   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              press_q, press_d;
   logic              release_q, release_d;

   // Synchronizer stage: resets to "not pressed" (raw high)
   sync_2ff #(
      .RST_VAL (1'b1)
   ) u_sync (
      .clk_i (Clock),
      .rst_i (Reset),
      .d_i   (ButtonRaw_n),
      .q_o   (raw_sync)
   );

   assign s = ~raw_sync;

`ifdef BUTTON_DEBOUNCER_LONGPRESS_EN
   localparam logic [LONG_W-1:0] HOLD_MAX  = LONG_W'(LONG_WINDOWS);
   localparam logic [LONG_W-1:0] HOLD_LAST = LONG_W'(LONG_WINDOWS - 1);

   logic [LONG_W-1:0] hold_q, hold_d;
   logic              long_q, long_d;
`endif

   // FSM stage: state and counter registers
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
`ifdef BUTTON_DEBOUNCER_LONGPRESS_EN
         hold_q    <= '0;
         long_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         press_q   <= press_d;
         release_q <= release_d;
`ifdef BUTTON_DEBOUNCER_LONGPRESS_EN
         hold_q    <= hold_d;
         long_q    <= long_d;
`endif
      end
   end

   // Next-state logic. The counter is only incremented while below
   // CNT_LAST, so it can never wrap.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
`ifdef BUTTON_DEBOUNCER_LONGPRESS_EN
      hold_d  = hold_q;
`endif
      case (state_q)
         IDLE: begin
            if (s) begin
               state_d = PRESS_WAIT;
               cnt_d   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!s) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PRESSED: begin
            if (!s) begin
               state_d = RELEASE_WAIT;
               cnt_d   = '0;
            end
`ifdef BUTTON_DEBOUNCER_LONGPRESS_EN
            // Count whole windows; stop once the threshold has been hit
            else if (hold_q < HOLD_MAX) begin
               if (cnt_q == CNT_LAST) begin
                  cnt_d  = '0;
                  hold_d = hold_q + 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
`endif
         end
         RELEASE_WAIT: begin
            // Returning to PRESSED keeps the hold count; partial window restarts
            if (s) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
`ifdef BUTTON_DEBOUNCER_LONGPRESS_EN
      if (state_d == IDLE) begin
         hold_d = '0;
      end
`endif
   end

   // Output logic: pulses are decoded from the transition and registered
   always_comb begin
      Level     = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
      press_d   = (state_q == PRESS_WAIT)   && (state_d == PRESSED);
      release_d = (state_q == RELEASE_WAIT) && (state_d == IDLE);
`ifdef BUTTON_DEBOUNCER_LONGPRESS_EN
      long_d    = (state_q == PRESSED) && s && (cnt_q == CNT_LAST) &&
                  (hold_q == HOLD_LAST);
`endif
   end

   assign Press   = press_q;
   assign Release = release_q;
`ifdef BUTTON_DEBOUNCER_LONGPRESS_EN
   assign LongPress = long_q;
`else
   assign LongPress = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with STABLE_CYCLES=4, LONG_WINDOWS=3.
// LongPress expectations follow BUTTON_DEBOUNCER_LONGPRESS_EN.
module tb_button_debouncer;
   import button_debouncer_pkg::*;

`ifdef BUTTON_DEBOUNCER_LONGPRESS_EN
   localparam bit LP_EN = 1'b1;
`else
   localparam bit LP_EN = 1'b0;
`endif

   logic Clock = 1'b0;
   logic Reset;
   logic ButtonRaw_n;
   logic Level, Press, Release, LongPress;

   int tests = 0;
   int fails = 0;

   button_debouncer #(
      .STABLE_CYCLES (4),
      .CNT_W         (4),
      .LONG_WINDOWS  (3),
      .LONG_W        (4)
   ) dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .ButtonRaw_n (ButtonRaw_n),
      .Level       (Level),
      .Press       (Press),
      .Release     (Release),
      .LongPress   (LongPress)
   );

   always #5 Clock = ~Clock;

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic check(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag, input state_t exp);
      tests++;
      assert (dut.state_q === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, dut.state_q, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic lvl, input logic prs,
                            input logic rel, input logic lng);
      check({tag, ".Level"},     Level,     lvl);
      check({tag, ".Press"},     Press,     prs);
      check({tag, ".Release"},   Release,   rel);
      check({tag, ".LongPress"}, LongPress, lng);
   endtask

   initial begin
      Reset       = 1'b1;
      ButtonRaw_n = 1'b1;
      step();
      step();
      check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);
      check_state("reset.state", IDLE);
      Reset = 1'b0;
      for (int i = 0; i < 3; i++) step();
      check_all("idle", 1'b0, 1'b0, 1'b0, 1'b0);

      // Clean press held long: Press after 7th edge, LongPress 12 later
      ButtonRaw_n = 1'b0;
      for (int k = 1; k <= 24; k++) begin
         step();
         check_all($sformatf("press_k%0d", k), (k >= 7), (k == 7), 1'b0,
                   LP_EN && (k == 19));
      end

      // Clean release: Release after 7th edge
      ButtonRaw_n = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         step();
         check_all($sformatf("release_k%0d", k), (k < 7), 1'b0, (k == 7), 1'b0);
      end
      check_state("release.state", IDLE);

      // Bounce: low 3, high 1, low 2, high
      ButtonRaw_n = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         if (k == 4) ButtonRaw_n = 1'b1;
         if (k == 5) ButtonRaw_n = 1'b0;
         if (k == 7) ButtonRaw_n = 1'b1;
         step();
         check_all($sformatf("bounce_k%0d", k), 1'b0, 1'b0, 1'b0, 1'b0);
      end
      check_state("bounce.state", IDLE);

      // Press again, then a short release bounce
      ButtonRaw_n = 1'b0;
      for (int k = 1; k <= 8; k++) step();
      check("rb_pressed.Level", Level, 1'b1);
      ButtonRaw_n = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         if (k == 3) ButtonRaw_n = 1'b0;
         step();
         check_all($sformatf("relbounce_k%0d", k), 1'b1, 1'b0, 1'b0, 1'b0);
      end
      check_state("relbounce.state", PRESSED);

      // Back to idle
      ButtonRaw_n = 1'b1;
      for (int k = 1; k <= 9; k++) step();
      check("rb_idle.Level", Level, 1'b0);
      check_state("rb_idle.state", IDLE);

      // Reset in PRESS_WAIT with the button held
      ButtonRaw_n = 1'b0;
      for (int k = 1; k <= 4; k++) step();
      check_state("rpw.pre_state", PRESS_WAIT);
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      check_all("rpw.reset", 1'b0, 1'b0, 1'b0, 1'b0);
      check_state("rpw.reset_state", IDLE);
      for (int k = 1; k <= 9; k++) begin
         step();
         check_all($sformatf("rpw_k%0d", k), (k >= 7), (k == 7), 1'b0, 1'b0);
      end

      // Reset while pressed clears Level
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      check_all("rpr.reset", 1'b0, 1'b0, 1'b0, 1'b0);
      check_state("rpr.state", IDLE);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 SHALL provide parameter STABLE_CYCLES, default 50000, cycles a raw level must hold before acceptance (1 ms at 50 MHz); legal range 2..2^CNT_W-1.
REQ-002 SHALL provide parameter CNT_W, default 16, width of the debounce counter.
REQ-003 SHALL provide parameter LONG_WINDOWS, default 1000, number of STABLE_CYCLES windows held before long-press; legal range 1..2^LONG_W-1.
REQ-004 SHALL provide parameter LONG_W, default 10, width of the hold-window counter.
REQ-005 Clock  in  1  single system clock; all state on rising edge.
REQ-006 Reset  in  1  synchronous, active-high reset.
REQ-007 ButtonRaw_n  in  1  asynchronous board button, active-low, bouncing.
REQ-008 Level  out  1  debounced pressed level, active-high.
REQ-009 Press  out  1  one-cycle pulse on accepted press.
REQ-010 Release  out  1  one-cycle pulse on accepted release.
REQ-011 LongPress  out  1  one-cycle pulse on long-press threshold; constant 0 when feature disabled.

Function
REQ-012 ButtonRaw_n SHALL pass through a 2-flop synchronizer; s = inverted synchronizer output (1 = pressed).
REQ-013 FSM states SHALL be IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-014 IDLE: s=1 -> PRESS_WAIT, counter cleared to 0.
REQ-015 PRESS_WAIT: s=0 -> IDLE, no pulse; else counter increments; s=1 with counter == STABLE_CYCLES-1 -> PRESSED.
REQ-016 PRESSED: s=0 -> RELEASE_WAIT, counter cleared to 0.
REQ-017 RELEASE_WAIT: s=1 -> PRESSED, no pulse, hold-window count preserved; s=0 with counter == STABLE_CYCLES-1 -> IDLE.
REQ-018 Press SHALL be registered, high exactly in the first cycle of PRESSED entered from PRESS_WAIT; Release likewise in the first cycle of IDLE entered from RELEASE_WAIT.
REQ-019 Level SHALL be 1 in PRESSED and RELEASE_WAIT, 0 in IDLE and PRESS_WAIT.
REQ-020 Latency: raw low first sampled at edge N, held stable -> Press high after edge N+STABLE_CYCLES+2; release symmetric.
REQ-021 Any bounce shorter than STABLE_CYCLES SHALL produce no pulse and no Level change.
REQ-022 Counter SHALL never wrap; it saturates at STABLE_CYCLES-1 by construction of the transitions.
REQ-023 Press and Release SHALL never assert in the same cycle; at most one Press per Release.

Reset
REQ-024 Reset SHALL set synchronizer flops to 1, state IDLE, all counters 0, Level/Press/Release/LongPress 0, on the next edge, overriding all other logic.
REQ-025 Reset mid-press SHALL discard progress; button still held after deassertion SHALL yield a fresh Press per REQ-020.

Configuration
REQ-026 Macro BUTTON_DEBOUNCER_LONGPRESS_EN defined: in PRESSED the debounce counter SHALL count windows of STABLE_CYCLES; hold-window counter increments per completed window; reaching LONG_WINDOWS SHALL pulse LongPress once, then stop counting until IDLE; hold count cleared on entering IDLE; frozen in RELEASE_WAIT.
REQ-027 Macro undefined: hold-window counter absent, LongPress tied 0, all other behaviour identical.

Structure
REQ-028 Shared package button_debouncer_pkg SHALL hold the state enum and default STABLE_CYCLES/LONG_WINDOWS constants.
REQ-029 Synchronizer SHALL be sub-module sync_2ff (reset value parameter, here 1).
REQ-030 Elaboration SHALL fail if STABLE_CYCLES < 2 or exceeds CNT_W range.

Verification (STABLE_CYCLES=4, LONG_WINDOWS=3)
REQ-031 Clean press: raw low from edge 10 -> Press high after edge 16 only, Level 1 from edge 16.
REQ-032 Bounce: raw low 3 cycles, high 1, low 2, high -> no Press, Level stays 0, state returns IDLE.
REQ-033 Release bounce: during RELEASE_WAIT raw low again after 2 cycles -> no Release, Level stays 1, back to PRESSED.
REQ-034 Long press (macro on): hold -> LongPress single pulse 12 cycles after Press; none further while held; macro off -> LongPress always 0.
REQ-035 Reset mid-PRESS_WAIT with raw held low: Reset 1 cycle -> outputs 0; Press after edge R+STABLE_CYCLES+3 counted from reset edge R.
